// File: rtl/hwpe_stream_tcdm_reorder_dynamic_pkg.sv
// Shared types and helpers for the runtime-reconfigurable TCDM channel reorder block.
// Holds the controller state encoding and the permutation legality check.
package hwpe_stream_tcdm_reorder_dynamic_pkg;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      SWITCH = 2'd2
   } reorder_dyn_state_t;

   localparam int unsigned MAX_CHAN   = 32;
   localparam int unsigned IDX_W_MAX  = 5;
   localparam int unsigned PERM_VEC_W = MAX_CHAN * IDX_W_MAX;

   // Returns 1 when the first nb_chan idx_w-bit entries are all in range and distinct.
   function automatic logic is_permutation(input logic [PERM_VEC_W-1:0] order,
                                           input int unsigned nb_chan,
                                           input int unsigned idx_w);
      logic [PERM_VEC_W-1:0] shifted;
      int unsigned idx;
      int unsigned seen;
      logic ok;
      seen = 0;
      ok   = 1'b1;
      for (int unsigned i = 0; i < MAX_CHAN; i++) begin
         if (i < nb_chan) begin
            shifted = order >> (i * idx_w);
            idx     = 32'(shifted) & ((32'd1 << idx_w) - 32'd1);
            if (idx >= nb_chan) begin
               ok = 1'b0;
            end else if (((seen >> idx) & 32'd1) != 32'd0) begin
               ok = 1'b0;
            end else begin
               seen = seen | (32'd1 << idx);
            end
         end
      end
      return ok;
   endfunction

endpackage

// File: rtl/hwpe_stream_tcdm_reorder_dynamic_if.sv
// One HWPE-Mem (TCDM) channel: request fields towards memory, grant/response back.
interface hwpe_stream_tcdm_reorder_dynamic_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic            req;
   logic            gnt;
   logic [AW-1:0]   add;
   logic            wen;
   logic [DW/8-1:0] be;
   logic [DW-1:0]   data;
   logic [DW-1:0]   r_data;
   logic            r_valid;

   modport master (output req, add, wen, be, data, input gnt, r_data, r_valid);
   modport slave  (input req, add, wen, be, data, output gnt, r_data, r_valid);
endinterface

// File: rtl/hwpe_stream_tcdm_reorder_dynamic_ctrl.sv
// Reorder controller: order handshake FSM, per-output outstanding counters and
// the request-enable mask that both drains and throttles the output channels.
module hwpe_stream_tcdm_reorder_dynamic_ctrl
   import hwpe_stream_tcdm_reorder_dynamic_pkg::*;
#(
   parameter int NB_CHAN         = 2,
   parameter int MAX_OUTSTANDING = 4,
   parameter int IDX_W           = $clog2(NB_CHAN)
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           clear_i,
   input  logic [NB_CHAN-1:0][IDX_W-1:0]  order_i,
   input  logic                           order_valid_i,
   output logic                           order_ready_o,
   output logic                           busy_o,
   output logic                           order_err_o,
   input  logic [NB_CHAN-1:0]             out_req_i,
   input  logic [NB_CHAN-1:0]             out_gnt_i,
   input  logic [NB_CHAN-1:0]             out_rvalid_i,
   output logic [NB_CHAN-1:0]             req_en_o,
   output logic [NB_CHAN-1:0][IDX_W-1:0]  order_q_o
);

   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

   reorder_dyn_state_t r_state, w_state_next;
   logic [NB_CHAN-1:0][IDX_W-1:0] r_order_q, r_order_pend, w_identity;
   logic [NB_CHAN-1:0] w_cnt_busy;
   logic w_legal, w_accept;

   generate
      for (genvar gi = 0; gi < NB_CHAN; gi++) begin : g_chan
         logic [CNT_W-1:0] r_cnt;
         logic w_inc;

         assign w_identity[gi] = IDX_W'(gi);
         assign w_inc          = out_req_i[gi] & out_gnt_i[gi];
         assign w_cnt_busy[gi] = (r_cnt != '0);
         assign req_en_o[gi]   = (r_state == RUN) && (r_cnt < MAX_CNT);

         // Grant and response in the same cycle cancel; stray responses never underflow.
         always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
               r_cnt <= '0;
            end else if (clear_i) begin
               r_cnt <= '0;
            end else if (w_inc && !out_rvalid_i[gi]) begin
               r_cnt <= r_cnt + 1'b1;
            end else if (!w_inc && out_rvalid_i[gi] && w_cnt_busy[gi]) begin
               r_cnt <= r_cnt - 1'b1;
            end
         end
      end
   endgenerate

   assign w_legal   = is_permutation(PERM_VEC_W'(r_order_pend), NB_CHAN, IDX_W);
   assign busy_o    = (r_state != RUN);
   assign order_q_o = r_order_q;

   always_comb begin
      w_state_next  = r_state;
      order_ready_o = 1'b0;
      order_err_o   = 1'b0;
      w_accept      = 1'b0;
      case (r_state)
         RUN: begin
            order_ready_o = 1'b1;
            if (order_valid_i) begin
               w_accept     = 1'b1;
               w_state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (!(|w_cnt_busy)) w_state_next = SWITCH;
         end
         SWITCH: begin
            order_err_o  = !w_legal;
            w_state_next = RUN;
         end
         default: w_state_next = RUN;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state      <= RUN;
         r_order_q    <= w_identity;
         r_order_pend <= w_identity;
      end else if (clear_i) begin
         r_state      <= RUN;
         r_order_q    <= w_identity;
         r_order_pend <= w_identity;
      end else begin
         r_state <= w_state_next;
         if (w_accept) r_order_pend <= order_i;
         if (r_state == SWITCH && w_legal) r_order_q <= r_order_pend;
      end
   end

endmodule

// File: rtl/hwpe_stream_tcdm_reorder_dynamic.sv
// Runtime-reconfigurable permutation of NB_CHAN TCDM channels; output i is driven
// by input order_q[i], responses are routed back to that same input.
module hwpe_stream_tcdm_reorder_dynamic
   import hwpe_stream_tcdm_reorder_dynamic_pkg::*;
#(
   parameter int NB_CHAN         = 2,
   parameter int AW              = 32,
   parameter int DW              = 32,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                                      clk_i,
   input  logic                                      rst_i,
   input  logic                                      clear_i,
   input  logic [NB_CHAN-1:0][$clog2(NB_CHAN)-1:0]   order_i,
   input  logic                                      order_valid_i,
   output logic                                      order_ready_o,
   output logic                                      busy_o,
   output logic                                      order_err_o,
   hwpe_stream_tcdm_reorder_dynamic_if.slave         in  [NB_CHAN],
   hwpe_stream_tcdm_reorder_dynamic_if.master        out [NB_CHAN]
);

   localparam int IDX_W = $clog2(NB_CHAN);

   logic [NB_CHAN-1:0]            w_in_req, w_in_wen;
   logic [AW-1:0]                 w_in_add  [NB_CHAN];
   logic [DW/8-1:0]               w_in_be   [NB_CHAN];
   logic [DW-1:0]                 w_in_data [NB_CHAN];
   logic [NB_CHAN-1:0]            w_out_req, w_out_gnt, w_out_rvalid, w_req_en;
   logic [DW-1:0]                 w_out_rdata [NB_CHAN];
   logic [NB_CHAN-1:0][IDX_W-1:0] w_order;

   hwpe_stream_tcdm_reorder_dynamic_ctrl #(
      .NB_CHAN         (NB_CHAN),
      .MAX_OUTSTANDING (MAX_OUTSTANDING),
      .IDX_W           (IDX_W)
   ) i_ctrl (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .clear_i       (clear_i),
      .order_i       (order_i),
      .order_valid_i (order_valid_i),
      .order_ready_o (order_ready_o),
      .busy_o        (busy_o),
      .order_err_o   (order_err_o),
      .out_req_i     (w_out_req),
      .out_gnt_i     (w_out_gnt),
      .out_rvalid_i  (w_out_rvalid),
      .req_en_o      (w_req_en),
      .order_q_o     (w_order)
   );

   generate
      for (genvar gi = 0; gi < NB_CHAN; gi++) begin : g_chan
         logic          w_gnt, w_rvalid;
         logic [DW-1:0] w_rdata;

         assign w_in_req[gi]     = in[gi].req;
         assign w_in_wen[gi]     = in[gi].wen;
         assign w_in_add[gi]     = in[gi].add;
         assign w_in_be[gi]      = in[gi].be;
         assign w_in_data[gi]    = in[gi].data;
         assign w_out_gnt[gi]    = out[gi].gnt;
         assign w_out_rvalid[gi] = out[gi].r_valid;
         assign w_out_rdata[gi]  = out[gi].r_data;

         assign w_out_req[gi] = w_in_req[w_order[gi]] & w_req_en[gi];
         assign out[gi].req   = w_out_req[gi];
         assign out[gi].add   = w_in_add[w_order[gi]];
         assign out[gi].wen   = w_in_wen[w_order[gi]];
         assign out[gi].be    = w_in_be[w_order[gi]];
         assign out[gi].data  = w_in_data[w_order[gi]];

         // Input gi collects its response from whichever output currently selects it.
         always_comb begin
            w_gnt    = 1'b0;
            w_rvalid = 1'b0;
            w_rdata  = '0;
            for (int k = 0; k < NB_CHAN; k++) begin
               if (w_order[k] == IDX_W'(gi)) begin
                  w_gnt    = w_out_gnt[k] & w_req_en[k];
                  w_rvalid = w_out_rvalid[k];
                  w_rdata  = w_out_rdata[k];
               end
            end
         end

         assign in[gi].gnt     = w_gnt;
         assign in[gi].r_valid = w_rvalid;
         assign in[gi].r_data  = w_rdata;
      end
   endgenerate

endmodule

// File: doc/hwpe_stream_tcdm_reorder_dynamic.md
# hwpe_stream_tcdm_reorder_dynamic

Runtime-reconfigurable permutation of NB_CHAN HWPE-Mem (TCDM) channels between an HWPE streamer and the TCDM interconnect, generalising static channel reordering to arbitrary address/data widths. The permutation is loaded through a valid/ready handshake and applied only after every output channel has drained its outstanding transactions. This keeps responses routed to the input that issued them. Per-channel outstanding counters also cap in-flight requests.

## Interface
- NB_CHAN, 2: number of HWPE-Mem channels (≥2).
- AW, 32: address width.
- DW, 32: data width; be width is DW/8.
- MAX_OUTSTANDING, 4: max granted-but-unanswered requests per output channel (≥1).
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- clear_i  in  1  synchronous clear; same effect as reset.
- order_i  in  NB_CHAN×$clog2(NB_CHAN)  requested permutation; entry i selects the input driving output i.
- order_valid_i  in  1  order_i is valid.
- order_ready_o  out  1  order accepted this cycle when valid&ready.
- busy_o  out  1  draining or switching.
- order_err_o  out  1  one-cycle pulse: last accepted order was not a permutation.
- in[NB_CHAN]  hwpe_stream_intf_tcdm.slave  AW/DW  streamer-side ports.
- out[NB_CHAN]  hwpe_stream_intf_tcdm.master  AW/DW  interconnect-side ports.

## Operation
- order_q holds the active permutation; reset/clear value is identity (order_q[i]=i).
- Request path, output i:
  - out[i].{add,wen,be,data} = in[order_q[i]].{…}.
  - out[i].req = in[order_q[i]].req & req_en[i].
  - req_en[i] = (state==RUN) & (cnt[i] < MAX_OUTSTANDING).
- Response path:
  - in[order_q[i]].{gnt,r_valid,r_data} = out[i].{gnt & req_en[i], r_valid, r_data}.
  - An input not selected by any output gets gnt=0, r_valid=0, r_data='0.
- Counter cnt[i], width $clog2(MAX_OUTSTANDING+1):
  - +1 on out[i].req & out[i].gnt.
  - −1 on out[i].r_valid.
  - Both in one cycle: unchanged.
  - r_valid with cnt=0: counter stays 0 (no underflow).
- FSM states: RUN, DRAIN, SWITCH.
  - RUN: order_ready_o=1. On order_valid_i, capture order_i into order_pend and go to DRAIN.
  - DRAIN: req_en=0 on all channels. Stay until all cnt[i]==0 (registered values), then go to SWITCH.
  - SWITCH: check order_pend for permutation. If legal, order_q<=order_pend; otherwise keep order_q and pulse order_err_o. Return to RUN.
- busy_o = (state != RUN).
- Reset/clear mid-operation: state=RUN, all counters 0, order_q identity, order_pend identity, order_err_o=0. Responses still in flight are forwarded using the identity order.
- Reset values: all out[i].req=0; order_ready_o=1; busy_o=0; order_err_o=0.

## Timing
- Request and response paths are combinational (zero added latency); gnt to the input is combinational from out gnt.
- Order handshake accepted at cycle t with no outstanding requests:
  - DRAIN at t+1.
  - SWITCH at t+2.
  - New order drives out at t+3.
- With outstanding requests, DRAIN holds until the cycle after the last r_valid zeroes the counters.
- order_valid_i in DRAIN or SWITCH is not accepted (ready=0); the source holds it.
- A channel at cnt==MAX_OUTSTANDING gets req deasserted. It re-enables the cycle after an r_valid decrements the counter.

## Structure
- hwpe_stream_package gains:
  - typedef enum reorder_dyn_state_t {RUN, DRAIN, SWITCH}.
  - A function checking a permutation vector for duplicates.
- One sub-module, hwpe_stream_tcdm_reorder_ctrl: FSM, cnt[] array, order_q/order_pend registers, req_en generation.
- Top module: interface binding and muxes only.

## Test plan
- Reset, no order load, NB_CHAN=4: read on in[2] appears on out[2]; r_data 0xCAFE returns on in[2].
- Idle load of order {3,2,1,0} at t: busy_o=1 at t+1..t+2; at t+3 an in[0] request appears on out[3].
- Two reads granted on out[1], then an order load: out.req stays 0 until both r_valid arrive. Responses reach the old inputs, then the switch occurs two cycles later.
- MAX_OUTSTANDING=2, memory withholds r_valid: third request on a channel sees gnt=0. It is granted the cycle after the first r_valid.
- Illegal order {1,1,0,2}: order_err_o pulses once in SWITCH; order_q remains unchanged.
- rst_i asserted during DRAIN with cnt=3: all counters 0, state RUN, order_ready_o=1, identity order immediately.
